// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the DataRAM arbiter between the core and the loader.
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CORE = 2'b01,
      LDR  = 2'b10
   } owner_e;

   localparam logic TAG_CORE = 1'b0;
   localparam logic TAG_LDR  = 1'b1;

   localparam int unsigned DEF_AW = 8;
   localparam int unsigned DEF_DW = 16;

endpackage

// File: rtl/dmem_arbiter_rr_hold_ctr.sv
// Grant decision for the DataRAM port: core priority, bounded by a count of
// consecutive core grants taken while the loader is waiting.
module rr_hold_ctr
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 4
)
(
   input  logic   CLK,
   input  logic   start,
   input  logic   core_req,
   input  logic   ldr_req,
   output logic   core_gnt,
   output logic   ldr_gnt,
   output owner_e owner
);

   localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

   owner_e     owner_r;
   owner_e     owner_nxt_s;
   logic [3:0] hold_r;
   logic [3:0] hold_nxt_s;

   // Next owner: core wins contention until it has held MAX_HOLD grants in a row.
   always_comb begin
      owner_nxt_s = IDLE;
      if (start) begin
         owner_nxt_s = IDLE;
      end else if (core_req && ldr_req) begin
         if (hold_r == MAX_HOLD_C) begin
            owner_nxt_s = LDR;
         end else begin
            owner_nxt_s = CORE;
         end
      end else if (core_req) begin
         owner_nxt_s = CORE;
      end else if (ldr_req) begin
         owner_nxt_s = LDR;
      end else begin
         owner_nxt_s = IDLE;
      end
   end

   // Grant decode and starvation count update.
   always_comb begin
      core_gnt   = 1'b0;
      ldr_gnt    = 1'b0;
      hold_nxt_s = hold_r;
      case (owner_nxt_s)
         CORE:    core_gnt = 1'b1;
         LDR:     ldr_gnt  = 1'b1;
         default: begin
            core_gnt = 1'b0;
            ldr_gnt  = 1'b0;
         end
      endcase
      if (!ldr_req || ldr_gnt) begin
         hold_nxt_s = 4'd0;
      end else if (core_gnt && (hold_r < MAX_HOLD_C)) begin
         hold_nxt_s = hold_r + 4'd1;
      end else begin
         hold_nxt_s = hold_r;
      end
   end

   // Owner and hold count registers.
   always_ff @(posedge CLK) begin
      if (start) begin
         owner_r <= IDLE;
         hold_r  <= 4'd0;
      end else begin
         owner_r <= owner_nxt_s;
         hold_r  <= hold_nxt_s;
      end
   end

   assign owner = owner_r;

endmodule

// File: rtl/dmem_arbiter.sv
// DataRAM port arbiter: muxes core/loader accesses onto the RAM and routes the
// one-cycle-latency read data back to whichever requester issued the read.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned AW       = DEF_AW,
   parameter int unsigned DW       = DEF_DW,
   parameter int unsigned MAX_HOLD = 4
)
(
   input  logic          CLK,
   input  logic          start,
   input  logic          core_req,
   input  logic          core_we,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic          core_gnt,
   output logic          core_rvalid,
   output logic [DW-1:0] core_rdata,
   input  logic          ldr_req,
   input  logic          ldr_we,
   input  logic [AW-1:0] ldr_addr,
   input  logic [DW-1:0] ldr_wdata,
   output logic          ldr_gnt,
   output logic          ldr_rvalid,
   output logic [DW-1:0] ldr_rdata,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic          mem_re,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [15:0]   core_stall_cnt
);

   owner_e      owner_s;
   logic        rd_valid_r;
   logic        rd_who_s;
   logic [15:0] stall_cnt_r;

   rr_hold_ctr #(.MAX_HOLD(MAX_HOLD)) u_hold_ctr (
      .CLK      (CLK),
      .start    (start),
      .core_req (core_req),
      .ldr_req  (ldr_req),
      .core_gnt (core_gnt),
      .ldr_gnt  (ldr_gnt),
      .owner    (owner_s)
   );

   // Drive the RAM from the granted requester; park at zero when idle.
   always_comb begin
      mem_addr  = {AW{1'b0}};
      mem_wdata = {DW{1'b0}};
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      if (core_gnt) begin
         mem_addr  = core_addr;
         mem_wdata = core_wdata;
         mem_we    = core_we;
         mem_re    = ~core_we;
      end else if (ldr_gnt) begin
         mem_addr  = ldr_addr;
         mem_wdata = ldr_wdata;
         mem_we    = ldr_we;
         mem_re    = ~ldr_we;
      end else begin
         mem_addr  = {AW{1'b0}};
         mem_wdata = {DW{1'b0}};
      end
   end

   // Read tag valid bit; owner already records who was granted last cycle,
   // so it serves as the tag's requester field.
   always_ff @(posedge CLK) begin
      if (start) begin
         rd_valid_r <= 1'b0;
      end else begin
         rd_valid_r <= mem_re;
      end
   end

   assign rd_who_s = (owner_s == LDR) ? TAG_LDR : TAG_CORE;

   // Return path; a pending read is dropped if reset lands on its data cycle.
   always_comb begin
      core_rvalid = 1'b0;
      ldr_rvalid  = 1'b0;
      core_rdata  = {DW{1'b0}};
      ldr_rdata   = {DW{1'b0}};
      if (rd_valid_r && !start) begin
         if (rd_who_s == TAG_LDR) begin
            ldr_rvalid = 1'b1;
            ldr_rdata  = mem_rdata;
         end else begin
            core_rvalid = 1'b1;
            core_rdata  = mem_rdata;
         end
      end else begin
         core_rvalid = 1'b0;
         ldr_rvalid  = 1'b0;
      end
   end

   // Saturating count of cycles where the core asked and was refused.
   always_ff @(posedge CLK) begin
      if (start) begin
         stall_cnt_r <= 16'd0;
      end else if (core_req && !core_gnt && (stall_cnt_r != 16'hFFFF)) begin
         stall_cnt_r <= stall_cnt_r + 16'd1;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign core_stall_cnt = stall_cnt_r;

endmodule
